// File: rtl/writeback_queue_if.sv
// Handshake, register-file write and bypass-lookup signals of the writeback queue.
// slave is the queue's view; master is the producer / register-file side.
interface writeback_queue_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  inValid;
  logic                  inReady;
  logic [4:0]            inRegister;
  logic [DATA_WIDTH-1:0] inData;

  logic                  writeStall;
  logic                  regWrite;
  logic [4:0]            writeRegister;
  logic [DATA_WIDTH-1:0] writeData;

  logic [4:0]            lookupRegister1;
  logic [4:0]            lookupRegister2;
  logic                  bypassHit1;
  logic                  bypassHit2;
  logic [DATA_WIDTH-1:0] bypassData1;
  logic [DATA_WIDTH-1:0] bypassData2;

  logic [CW-1:0]         pendingCount;
  logic                  empty;

  modport slave (
    input  inValid, inRegister, inData, writeStall, lookupRegister1, lookupRegister2,
    output inReady, regWrite, writeRegister, writeData,
           bypassHit1, bypassHit2, bypassData1, bypassData2, pendingCount, empty
  );

  modport master (
    output inValid, inRegister, inData, writeStall, lookupRegister1, lookupRegister2,
    input  inReady, regWrite, writeRegister, writeData,
           bypassHit1, bypassHit2, bypassData1, bypassData2, pendingCount, empty
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback FIFO feeding one register-file write port, with two
// combinational bypass lookups returning the youngest pending value per register.

// One bypass port: scans entries oldest->youngest so the last match wins.
module wbq_lookup #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic [DEPTH-1:0]                 vld,
  input  logic [DEPTH-1:0][4:0]            rd,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] data,
  input  logic [4:0]                       lookup,
  output logic                             hit,
  output logic [DATA_WIDTH-1:0]            hit_data
);
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (lookup != 5'd0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (vld[k] && rd[k] == lookup) begin
          hit      = 1'b1;
          hit_data = data[k];
        end
      end
    end
  end
endmodule

module writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic               clock,
  input  logic               resetN,
  writeback_queue_if.slave   wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          push, pop, is_empty;

  assign is_empty         = (count == '0);
  assign wb.empty         = is_empty;
  assign wb.pendingCount  = count;
  assign wb.inReady       = (count < CW'(DEPTH));
  assign pop              = !is_empty && !wb.writeStall;
  assign wb.regWrite      = pop;
  // x0 requests complete the handshake but never occupy a slot
  assign push             = wb.inValid && wb.inReady && (wb.inRegister != 5'd0);

  assign wb.writeRegister = is_empty ? 5'd0 : mem[rd_ptr].rd;
  assign wb.writeData     = is_empty ? '0   : mem[rd_ptr].data;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{rd: wb.inRegister, data: wb.inData};
  end

  // Entries re-ordered by age (index 0 = head) for the bypass scan.
  logic [DEPTH-1:0]                 ord_vld;
  logic [DEPTH-1:0][4:0]            ord_rd;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ord_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    localparam logic [PW-1:0] OFF = PW'(k);
    logic [PW-1:0] idx;
    assign idx         = rd_ptr + OFF;
    assign ord_vld[k]  = (CW'(k) < count);
    assign ord_rd[k]   = mem[idx].rd;
    assign ord_data[k] = mem[idx].data;
  end

  logic [1:0][4:0]            lk;
  logic [1:0]                 hit;
  logic [1:0][DATA_WIDTH-1:0] hdata;

  assign lk[0] = wb.lookupRegister1;
  assign lk[1] = wb.lookupRegister2;

  for (genvar p = 0; p < 2; p++) begin : g_lookup
    wbq_lookup #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_lookup (
      .vld      (ord_vld),
      .rd       (ord_rd),
      .data     (ord_data),
      .lookup   (lk[p]),
      .hit      (hit[p]),
      .hit_data (hdata[p])
    );
  end

  assign wb.bypassHit1  = hit[0];
  assign wb.bypassHit2  = hit[1];
  assign wb.bypassData1 = hdata[0];
  assign wb.bypassData2 = hdata[1];
endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: a reference model queues expected writes
// on acceptance; a negedge monitor pops and compares every register-file write.
module tb_writeback_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } exp_t;

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  writeback_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) wb();

  writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clock  (clock),
    .resetN (resetN),
    .wb     (wb.slave)
  );

  always #5 clock = ~clock;

  exp_t sb[$];
  int   mcount = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  bit   mon_en = 1'b0;

  // Reference model: occupancy and acceptance order
  initial forever begin
    @(posedge clock or negedge resetN);
    if (!resetN) begin
      mcount = 0;
      sb.delete();
    end else begin
      bit mpush, mpop;
      mpush = wb.inValid && (mcount < DEPTH) && (wb.inRegister != 5'd0);
      mpop  = (mcount != 0) && !wb.writeStall;
      if (mpush) sb.push_back('{rd: wb.inRegister, data: wb.inData});
      mcount = mcount + int'(mpush) - int'(mpop);
    end
  end

  function automatic void exp_bypass(input logic [4:0] lk, output bit hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (lk != 5'd0)
      foreach (sb[i]) if (sb[i].rd == lk) begin hit = 1'b1; d = sb[i].data; end
  endfunction

  // Monitor: samples mid-cycle, compares before popping the scoreboard
  initial forever begin
    @(negedge clock);
    if (mon_en && resetN) begin
      bit            eh1, eh2;
      logic [DW-1:0] ed1, ed2;
      exp_t          e;
      exp_bypass(wb.lookupRegister1, eh1, ed1);
      exp_bypass(wb.lookupRegister2, eh2, ed2);
      n_cmp++;
      if (wb.bypassHit1 !== eh1 || wb.bypassData1 !== ed1) begin
        n_bad++;
        $display("FAIL mon_bypass1: got hit=%0b data=%h want hit=%0b data=%h", wb.bypassHit1, wb.bypassData1, eh1, ed1);
      end
      n_cmp++;
      if (wb.bypassHit2 !== eh2 || wb.bypassData2 !== ed2) begin
        n_bad++;
        $display("FAIL mon_bypass2: got hit=%0b data=%h want hit=%0b data=%h", wb.bypassHit2, wb.bypassData2, eh2, ed2);
      end
      n_cmp++;
      if (wb.pendingCount !== CW'(mcount) || wb.empty !== (mcount == 0) || wb.inReady !== (mcount < DEPTH)) begin
        n_bad++;
        $display("FAIL mon_count: got cnt=%0d empty=%0b rdy=%0b want cnt=%0d", wb.pendingCount, wb.empty, wb.inReady, mcount);
      end
      n_cmp++;
      if (wb.regWrite !== ((mcount != 0) && !wb.writeStall)) begin
        n_bad++;
        $display("FAIL mon_regwrite: got %0b want %0b", wb.regWrite, (mcount != 0) && !wb.writeStall);
      end
      if (wb.regWrite === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL mon_unexpected_write: got rd=%0d data=%h want no write", wb.writeRegister, wb.writeData);
        end else begin
          e = sb.pop_front();
          if (wb.writeRegister !== e.rd || wb.writeData !== e.data) begin
            n_bad++;
            $display("FAIL mon_write: got rd=%0d data=%h want rd=%0d data=%h", wb.writeRegister, wb.writeData, e.rd, e.data);
          end
        end
      end else if (mcount == 0) begin
        n_cmp++;
        if (wb.writeRegister !== 5'd0 || wb.writeData !== '0) begin
          n_bad++;
          $display("FAIL mon_idle_bus: got rd=%0d data=%h want 0", wb.writeRegister, wb.writeData);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int t;
    wb.inValid    = 1'b0;
    wb.writeStall = 1'b0;
    t = 0;
    while (mcount != 0 && t < 40) begin cyc(); t++; end
    cyc();
    n_cmp++;
    if (mcount != 0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got pending=%0d sb=%0d want 0", mcount, sb.size());
    end
  endtask

  task automatic test_reset();
    wb.inValid = 1'b1; wb.inRegister = 5'd3; wb.inData = 64'h1234;
    wb.writeStall = 1'b0; wb.lookupRegister1 = 5'd3; wb.lookupRegister2 = 5'd3;
    resetN = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (wb.pendingCount !== '0 || wb.empty !== 1'b1 || wb.inReady !== 1'b1 || wb.regWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got cnt=%0d empty=%0b rdy=%0b wr=%0b want 0 1 1 0", wb.pendingCount, wb.empty, wb.inReady, wb.regWrite);
    end
    n_cmp++;
    if (wb.writeRegister !== 5'd0 || wb.writeData !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: got rd=%0d data=%h want 0", wb.writeRegister, wb.writeData);
    end
    n_cmp++;
    if (wb.bypassHit1 !== 1'b0 || wb.bypassHit2 !== 1'b0 || wb.bypassData1 !== '0 || wb.bypassData2 !== '0) begin
      n_bad++;
      $display("FAIL reset_bypass: got h=%0b%0b d1=%h d2=%h want 0", wb.bypassHit1, wb.bypassHit2, wb.bypassData1, wb.bypassData2);
    end
    wb.inValid = 1'b0; wb.lookupRegister1 = 5'd0; wb.lookupRegister2 = 5'd0;
    #2 resetN = 1'b1;
    mon_en = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    wb.inValid = 1'b1; wb.inRegister = 5'd5; wb.inData = 64'hDEAD;
    cyc();
    wb.inValid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (wb.regWrite !== 1'b1 || wb.writeRegister !== 5'd5 || wb.writeData !== 64'hDEAD) begin
      n_bad++;
      $display("FAIL single_write: got wr=%0b rd=%0d data=%h want 1 5 dead", wb.regWrite, wb.writeRegister, wb.writeData);
    end
    cyc();
    @(negedge clock);
    n_cmp++;
    if (wb.empty !== 1'b1) begin
      n_bad++;
      $display("FAIL single_empty: got %0b want 1", wb.empty);
    end
  endtask

  task automatic test_fill_stall();
    wb.writeStall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wb.inValid = 1'b1; wb.inRegister = 5'(i); wb.inData = 64'(i * 32'h101);
      cyc();
    end
    @(negedge clock);
    n_cmp++;
    if (wb.inReady !== 1'b0 || wb.pendingCount !== CW'(4)) begin
      n_bad++;
      $display("FAIL fill_full: got rdy=%0b cnt=%0d want 0 4", wb.inReady, wb.pendingCount);
    end
    wb.inRegister = 5'd9; wb.inData = 64'h999;
    cyc();
    wb.inValid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (wb.pendingCount !== CW'(4)) begin
      n_bad++;
      $display("FAIL fill_ignored: got cnt=%0d want 4", wb.pendingCount);
    end
    cyc();
    wb.writeStall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      n_cmp++;
      if (wb.regWrite !== 1'b1 || wb.writeRegister !== 5'(i)) begin
        n_bad++;
        $display("FAIL fill_order: got wr=%0b rd=%0d want 1 %0d", wb.regWrite, wb.writeRegister, i);
      end
      cyc();
    end
    drain();
  endtask

  task automatic test_bypass();
    wb.writeStall = 1'b1;
    wb.lookupRegister1 = 5'd7; wb.lookupRegister2 = 5'd0;
    wb.inValid = 1'b1; wb.inRegister = 5'd7; wb.inData = 64'h11;
    cyc();
    wb.inData = 64'h22;
    @(negedge clock);
    n_cmp++;
    if (wb.bypassHit1 !== 1'b1 || wb.bypassData1 !== 64'h11) begin
      n_bad++;
      $display("FAIL bypass_inflight: got hit=%0b data=%h want 1 11", wb.bypassHit1, wb.bypassData1);
    end
    cyc();
    wb.inValid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (wb.bypassHit1 !== 1'b1 || wb.bypassData1 !== 64'h22) begin
      n_bad++;
      $display("FAIL bypass_youngest: got hit=%0b data=%h want 1 22", wb.bypassHit1, wb.bypassData1);
    end
    n_cmp++;
    if (wb.bypassHit2 !== 1'b0 || wb.bypassData2 !== '0) begin
      n_bad++;
      $display("FAIL bypass_x0: got hit=%0b data=%h want 0 0", wb.bypassHit2, wb.bypassData2);
    end
    wb.lookupRegister2 = 5'd8;
    cyc();
    drain();
    wb.lookupRegister1 = 5'd0; wb.lookupRegister2 = 5'd0;
  endtask

  task automatic test_x0();
    wb.inValid = 1'b1; wb.inRegister = 5'd0; wb.inData = 64'hFF;
    @(negedge clock);
    n_cmp++;
    if (wb.inReady !== 1'b1) begin
      n_bad++;
      $display("FAIL x0_ready: got %0b want 1", wb.inReady);
    end
    cyc();
    wb.inValid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (wb.pendingCount !== '0 || wb.regWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL x0_discard: got cnt=%0d wr=%0b want 0 0", wb.pendingCount, wb.regWrite);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      wb.inValid = 1'b1; wb.inRegister = 5'(i + 1); wb.inData = {$urandom, $urandom};
      if (i > 0) begin
        @(negedge clock);
        n_cmp++;
        if (wb.pendingCount !== CW'(1) || wb.regWrite !== 1'b1) begin
          n_bad++;
          $display("FAIL stream_steady: got cnt=%0d wr=%0b want 1 1 (step %0d)", wb.pendingCount, wb.regWrite, i);
        end
      end
      cyc();
    end
    wb.inValid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    wb.writeStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb.inValid = 1'b1; wb.inRegister = 5'(20 + i); wb.inData = 64'(i + 100);
      cyc();
    end
    wb.inValid = 1'b0;
    wb.writeStall = 1'b0;
    @(negedge clock);
    #2 resetN = 1'b0;
    #1;
    n_cmp++;
    if (wb.regWrite !== 1'b0 || wb.pendingCount !== '0 || wb.empty !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid: got wr=%0b cnt=%0d empty=%0b want 0 0 1", wb.regWrite, wb.pendingCount, wb.empty);
    end
    #7 resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++;
      if (wb.regWrite !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_no_write: got wr=%0b rd=%0d want 0", wb.regWrite, wb.writeRegister);
      end
    end
    cyc();
    wb.inValid = 1'b1; wb.inRegister = 5'd3; wb.inData = 64'h3333;
    cyc();
    wb.inValid = 1'b0;
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      wb.inValid         = 1'($urandom_range(0, 1));
      wb.inRegister      = 5'($urandom_range(0, 7));
      wb.inData          = {$urandom, $urandom};
      wb.writeStall      = ($urandom_range(0, 3) == 0);
      wb.lookupRegister1 = 5'($urandom_range(0, 7));
      wb.lookupRegister2 = 5'($urandom_range(0, 7));
      cyc();
    end
    drain();
  endtask

  initial begin
    wb.inValid = 1'b0; wb.inRegister = '0; wb.inData = '0; wb.writeStall = 1'b0;
    wb.lookupRegister1 = '0; wb.lookupRegister2 = '0;
    test_reset();
    test_single();
    test_fill_stall();
    test_bypass();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
